// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the CPU-side byte-wide memory bus controller.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MEM_WMASK_BYTE = 2'b01;
  localparam logic       WSTROBE_IDLE   = 1'b1;
  localparam logic       WSTROBE_ACTIVE = 1'b0;

  function automatic logic is_strobe_state(input state_t s);
    return (s == LO) || (s == HI);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_addr_inc.sv
// High-byte address generator for 16-bit little-endian accesses.
module mem_bus_ctrl_addr_inc #(
  parameter bit PAGE_WRAP = 1'b0,
  parameter int ADDR_W    = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] hi_addr
);

  generate
    if (PAGE_WRAP) begin : g_page_wrap
      // Carry out of the low byte is dropped, like the 6502 JMP (ind) fetch.
      assign hi_addr = {addr[ADDR_W-1:8], addr[7:0] + 8'd1};
    end else begin : g_linear
      assign hi_addr = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  endgenerate

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences single-cycle CPU requests into one or two byte accesses on the
// byte-wide memory and returns the assembled result with a busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for req; memory strobes inactive
//   LO    | low byte access at the latched address
//   HI    | high byte access at the incremented address (word only)
//   DONE  | done pulse; request inputs ignored
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter bit PAGE_WRAP = 1'b0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] hi_addr;
  logic [15:0]       wdata_q;
  logic              we_q;
  logic              word_q;

  mem_bus_ctrl_addr_inc #(
    .PAGE_WRAP (PAGE_WRAP),
    .ADDR_W    (ADDR_W)
  ) u_addr_inc (
    .addr    (addr_q),
    .hi_addr (hi_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 16'h0000;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            word_q  <= word;
            busy    <= 1'b1;
            state   <= LO;
          end
        end
        LO: begin
          if (!we_q) begin
            rdata[7:0] <= mem_rdata;
            if (!word_q) rdata[15:8] <= 8'h00;
          end
          if (word_q) begin
            state <= HI;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        HI: begin
          if (!we_q) rdata[15:8] <= mem_rdata;
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The high-byte write strobe is suppressed by rst so an aborted word write
  // never lands its second byte.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = WSTROBE_IDLE;
    mem_address = addr_q;
    mem_wdata   = 8'h00;
    if (is_strobe_state(state)) begin
      if (state == HI) mem_address = hi_addr;
      if (we_q) begin
        mem_wdata = (state == HI) ? wdata_q[15:8] : wdata_q[7:0];
        if (state == LO || !rst) mem_write = WSTROBE_ACTIVE;
      end else begin
        mem_read = 1'b1;
      end
    end
  end

  assign mem_wmask = MEM_WMASK_BYTE;

endmodule
